video_dram_sched: RTL

//  Slot scheduler for the video DRAM port. Shares one read slot per DRAM cycle between the

---
 rtl/video_dram_sched.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/video_dram_sched.sv
// Video DRAM slot scheduler: one read slot per DRAM cycle shared by
// video bursts, tilemap, TS renderer and Z80, with data-aligned strobes.
module video_dram_sched #(
  parameter int AW       = 21,
  parameter int DATA_LAT = 3
) (
  input  logic          clk,
  input  logic          res_n,
  input  logic          slot_stb,
  input  logic          vid_go,
  input  logic [4:0]    vid_bw,
  input  logic [AW-1:0] vid_addr,
  input  logic          tm_req,
  input  logic [AW-1:0] tm_addr,
  input  logic          ts_req,
  input  logic [AW-1:0] ts_addr,
  input  logic          z_req,
  input  logic [AW-1:0] z_addr,
  input  logic          z_lp,
  output logic [AW-1:0] dram_addr,
  output logic          dram_req,
  output logic          vid_next,
  output logic          vid_pre_next,
  output logic          tm_next,
  output logic          ts_pre_next,
  output logic          ts_next,
  output logic          z_next,
  output logic          busy
);

  typedef enum logic {IDLE, VBURST} state_t;

  localparam logic [1:0] OW_VID = 2'd0;
  localparam logic [1:0] OW_TM  = 2'd1;
  localparam logic [1:0] OW_TS  = 2'd2;
  localparam logic [1:0] OW_Z   = 2'd3;

  state_t                     state;
  logic [5:0]                 cnt;
  logic [AW-1:0]              burst_addr;
  logic [DATA_LAT-1:0]        p_vld;
  logic [DATA_LAT-1:0][1:0]   p_own;

  logic          pend_tm, pend_ts, pend_z;
  logic          tm_ok, ts_ok, z_ok, z_hi;
  logic          enter, g_vid, g_tm, g_ts, g_z;
  logic          g_vld;
  logic [1:0]    g_own;
  logic [AW-1:0] g_addr;

  // A requester with a tag still in flight must not be granted again.
  always_comb begin
    pend_tm = 1'b0;
    pend_ts = 1'b0;
    pend_z  = 1'b0;
    for (int i = 0; i < DATA_LAT; i++) begin
      pend_tm = pend_tm | (p_vld[i] & (p_own[i] == OW_TM));
      pend_ts = pend_ts | (p_vld[i] & (p_own[i] == OW_TS));
      pend_z  = pend_z  | (p_vld[i] & (p_own[i] == OW_Z));
    end
  end

  assign tm_ok = tm_req & ~pend_tm;
  assign ts_ok = ts_req & ~pend_ts;
  assign z_ok  = z_req  & ~pend_z;
  assign z_hi  = z_ok & ~z_lp;

  assign enter = (state == IDLE) && vid_go;
  assign g_vid = enter || ((state == VBURST) && (cnt != 6'd1));
  assign g_tm  = ~g_vid & ~z_hi & tm_ok;
  assign g_ts  = ~g_vid & ~z_hi & ~tm_ok & ts_ok;
  assign g_z   = ~g_vid & z_ok & (~z_lp | (~tm_ok & ~ts_ok));

  always_comb begin
    g_vld  = 1'b1;
    g_own  = OW_VID;
    g_addr = burst_addr + 1'b1;
    unique case (1'b1)
      g_vid: g_addr = enter ? vid_addr : burst_addr + 1'b1;
      g_tm: begin
        g_own  = OW_TM;
        g_addr = tm_addr;
      end
      g_ts: begin
        g_own  = OW_TS;
        g_addr = ts_addr;
      end
      g_z: begin
        g_own  = OW_Z;
        g_addr = z_addr;
      end
      default: g_vld = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state      <= IDLE;
      cnt        <= '0;
      burst_addr <= '0;
      dram_addr  <= '0;
      dram_req   <= 1'b0;
      p_vld      <= '0;
      p_own      <= '0;
    end else begin
      p_vld <= {p_vld[DATA_LAT-2:0], slot_stb & g_vld};
      p_own <= {p_own[DATA_LAT-2:0], g_own};
      if (slot_stb) begin
        dram_req <= g_vld;
        if (g_vld)
          dram_addr <= g_addr;
        unique case (state)
          IDLE: begin
            if (vid_go) begin
              state      <= VBURST;
              cnt        <= (vid_bw == 5'd0) ? 6'd32 : {1'b0, vid_bw};
              burst_addr <= vid_addr;
            end
          end
          VBURST: begin
            if (cnt == 6'd1) begin
              state <= IDLE;
            end else begin
              cnt        <= cnt - 6'd1;
              burst_addr <= burst_addr + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy         = (state == VBURST);
  assign vid_next     = p_vld[DATA_LAT-1] & (p_own[DATA_LAT-1] == OW_VID);
  assign tm_next      = p_vld[DATA_LAT-1] & (p_own[DATA_LAT-1] == OW_TM);
  assign ts_next      = p_vld[DATA_LAT-1] & (p_own[DATA_LAT-1] == OW_TS);
  assign z_next       = p_vld[DATA_LAT-1] & (p_own[DATA_LAT-1] == OW_Z);
  assign vid_pre_next = p_vld[DATA_LAT-2] & (p_own[DATA_LAT-2] == OW_VID);
  assign ts_pre_next  = p_vld[DATA_LAT-2] & (p_own[DATA_LAT-2] == OW_TS);

endmodule
